gpio_in_debounce_pio: RTL and testbench

Parametrised successor to the 4-bit DIP-switch input PIO, used as an Avalon-MM slave on the HPS-to-FPGA lightweight bridge.
- Adds a configurable input synchroniser and per-bit debounce filtering.
- Edge detection is selectable per bit: rising, falling, or both.
- Write-1-to-clear edge capture: a simultaneous new edge is never lost.
- Adds a masked-interrupt status register.
- Serves DIP switches, push-buttons and limit switches of any width up to 32.

---
 rtl/gpio_in_debounce_pio.sv | 109 ++++++++++
 tb/tb_gpio_in_debounce_pio.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_in_debounce_pio.sv
// Avalon-MM input PIO with synchroniser, per-bit debounce, selectable edge capture
// (write-1-to-clear) and a masked interrupt.
module gpio_in_debounce_pio #(
  parameter int unsigned      WIDTH       = 4,
  parameter int unsigned      SYNC_STAGES = 2,
  parameter int unsigned      DEB_W       = 16,
  parameter logic [DEB_W-1:0] DEB_RESET   = '0,
  parameter logic [WIDTH-1:0] EDGE_RESET  = '1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq,
  input  logic [WIDTH-1:0] in_port
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] sync_v;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] irq_mask_q, rise_en_q, fall_en_q;
  logic [WIDTH-1:0] edge_capture_q, edge_capture_d;
  logic [WIDTH-1:0] rise, fall, clr;
  logic [DEB_W-1:0] deb_limit_q;
  logic [DEB_W-1:0] cnt_q [WIDTH];
  logic [DEB_W-1:0] cnt_d [WIDTH];
  logic             wr_en;
  logic [31:0]      rd_d;
  logic             unused_wdata;

  assign sync_v       = sync_q[SYNC_STAGES-1];
  assign wr_en        = chipselect & ~write_n;
  assign unused_wdata = ^writedata;

  // Counter only advances while below the limit, so it cannot wrap.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync_v[i] != stable_q[i]) begin
        if (cnt_q[i] >= deb_limit_q) begin
          stable_d[i] = sync_v[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign rise = stable_d & ~stable_q & rise_en_q;
  assign fall = ~stable_d & stable_q & fall_en_q;
  assign clr  = (wr_en && address == 3'd3) ? writedata[WIDTH-1:0] : '0;

  // A new edge in the same cycle as its clear is kept.
  assign edge_capture_d = (edge_capture_q & ~clr) | rise | fall;

  always_comb begin
    rd_d = '0;
    case (address)
      3'd0:    rd_d[WIDTH-1:0] = stable_q;
      3'd1:    rd_d[WIDTH-1:0] = sync_v;
      3'd2:    rd_d[WIDTH-1:0] = irq_mask_q;
      3'd3:    rd_d[WIDTH-1:0] = edge_capture_q;
      3'd4:    rd_d[WIDTH-1:0] = rise_en_q;
      3'd5:    rd_d[WIDTH-1:0] = fall_en_q;
      3'd6:    rd_d[DEB_W-1:0] = deb_limit_q;
      default: rd_d[WIDTH-1:0] = edge_capture_q & irq_mask_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q         <= '0;
      stable_q       <= '0;
      irq_mask_q     <= '0;
      rise_en_q      <= EDGE_RESET;
      fall_en_q      <= EDGE_RESET;
      edge_capture_q <= '0;
      deb_limit_q    <= DEB_RESET;
      readdata       <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync_q         <= {sync_q[SYNC_STAGES-2:0], in_port};
      stable_q       <= stable_d;
      edge_capture_q <= edge_capture_d;
      readdata       <= rd_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      if (wr_en) begin
        case (address)
          3'd2:    irq_mask_q  <= writedata[WIDTH-1:0];
          3'd4:    rise_en_q   <= writedata[WIDTH-1:0];
          3'd5:    fall_en_q   <= writedata[WIDTH-1:0];
          3'd6:    deb_limit_q <= writedata[DEB_W-1:0];
          default: ;
        endcase
      end
    end
  end

  assign irq = |(edge_capture_q & irq_mask_q);

endmodule

// File: tb/tb_gpio_in_debounce_pio.sv
// Bench for gpio_in_debounce_pio: a WIDTH=4 instance checked every cycle against a
// behavioural model, plus a WIDTH=32 instance on the same bus for width checks.
module tb_gpio_in_debounce_pio;

  localparam int S = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata, readdata32;
  logic        irq, irq32;
  logic [3:0]  in_port;
  logic [31:0] in32;

  int checks = 0;
  int errors = 0;

  gpio_in_debounce_pio dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .in_port    (in_port)
  );

  gpio_in_debounce_pio #(.WIDTH(32)) dut32 (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata32),
    .irq        (irq32),
    .in_port    (in32)
  );

  always #5 clk = ~clk;

  // Model of the 4-bit instance: a bit's debounced value flips once the synchronised
  // input has disagreed with it on each of the last deb_limit+1 samples.
  logic [3:0]  m_pipe [S];
  logic [3:0]  m_hist [64];
  logic [3:0]  m_stable, m_ec, m_mask, m_rise, m_fall;
  logic [15:0] m_lim;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < S; k++) m_pipe[k] = '0;
    for (int k = 0; k < 64; k++) m_hist[k] = '0;
    m_stable = '0; m_ec = '0; m_mask = '0;
    m_rise = 4'hF; m_fall = 4'hF; m_lim = '0;
  endtask

  task automatic cycle(input logic [2:0] a, input logic cs, input logic wn,
                       input logic [31:0] d);
    logic [31:0] exp_rd;
    logic [3:0]  s, new_st, rise, fall, clr;
    logic        flip, we;
    address = a; chipselect = cs; write_n = wn; writedata = d;
    case (a)
      3'd0:    exp_rd = {28'b0, m_stable};
      3'd1:    exp_rd = {28'b0, m_pipe[S-1]};
      3'd2:    exp_rd = {28'b0, m_mask};
      3'd3:    exp_rd = {28'b0, m_ec};
      3'd4:    exp_rd = {28'b0, m_rise};
      3'd5:    exp_rd = {28'b0, m_fall};
      3'd6:    exp_rd = {16'b0, m_lim};
      default: exp_rd = {28'b0, m_ec & m_mask};
    endcase
    s = m_pipe[S-1];
    for (int k = 63; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = s;
    new_st = m_stable;
    for (int b = 0; b < 4; b++) begin
      flip = 1'b1;
      for (int k = 0; k <= int'(m_lim) && k < 64; k++)
        if (m_hist[k][b] == m_stable[b]) flip = 1'b0;
      if (flip) new_st[b] = ~m_stable[b];
    end
    rise = new_st & ~m_stable & m_rise;
    fall = ~new_st & m_stable & m_fall;
    we = cs & ~wn;
    clr = (we && a == 3'd3) ? d[3:0] : 4'h0;
    m_ec = (m_ec & ~clr) | rise | fall;
    if (we) begin
      case (a)
        3'd2: m_mask = d[3:0];
        3'd4: m_rise = d[3:0];
        3'd5: m_fall = d[3:0];
        3'd6: m_lim  = d[15:0];
        default: ;
      endcase
    end
    m_stable = new_st;
    for (int k = S-1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
    m_pipe[0] = in_port;
    @(posedge clk);
    #1;
    chk("readdata", readdata, exp_rd);
    chk("irq", {31'b0, irq}, {31'b0, |(m_ec & m_mask)});
  endtask

  task automatic rd(input logic [2:0] a);
    cycle(a, 1'b0, 1'b1, 32'h0);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    cycle(a, 1'b1, 1'b0, d);
  endtask

  logic [31:0] exp4  [8];
  logic [31:0] exp32 [8];
  int          lat;

  initial begin
    exp4  = '{0, 0, 0, 0, 32'hF, 32'hF, 0, 0};
    exp32 = '{0, 0, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0};
    reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; in_port = '0; in32 = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rd", readdata, 32'h0);
    chk("reset_irq", {31'b0, irq}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Random traffic: inputs, strobes and short debounce limits.
    for (int n = 0; n < 600; n++) begin
      logic [2:0]  a;
      logic [31:0] d;
      if ($urandom_range(0, 3) == 0) in_port = 4'($urandom);
      in32 = $urandom;
      a = 3'($urandom);
      d = (a == 3'd6) ? 32'($urandom_range(0, 4)) : $urandom;
      cycle(a, 1'($urandom), ($urandom_range(0, 2) != 0), d);
    end

    // Reset in the middle of traffic.
    in_port = 4'hF;
    reset_n = 1'b0;
    #2;
    chk("midreset_rd", readdata, 32'h0);
    chk("midreset_rd32", readdata32, 32'h0);
    chk("midreset_irq", {31'b0, irq}, 32'h0);
    @(negedge clk);
    in_port = 4'h0; in32 = '0;
    reset_n = 1'b1;
    model_reset();
    rd(3'd0);
    for (int a = 0; a < 8; a++) begin
      rd(3'(a));
      chk($sformatf("rst_val%0d", a), readdata, exp4[a]);
      chk($sformatf("rst_val32_%0d", a), readdata32, exp32[a]);
    end
    chk("rst_irq", {31'b0, irq}, 32'h0);

    // Debounce filter: an 8-cycle pulse against limit 10 is rejected.
    wr(3'd6, 32'd10);
    in_port[0] = 1'b1;
    repeat (8) rd(3'd0);
    in_port[0] = 1'b0;
    repeat (20) rd(3'd0);
    chk("filter_stable", readdata, 32'h0);
    rd(3'd3);
    chk("filter_capture", readdata, 32'h0);

    // Debounce accept: stable updates 13 edges after the change, seen one read later.
    in_port[0] = 1'b1;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      rd(3'd0);
      if (readdata[0] === 1'b1) begin
        lat = n;
        break;
      end
    end
    chk("accept_latency", 32'(lat), 32'd14);
    rd(3'd3);
    chk("accept_capture", readdata, 32'h1);

    // Edge select: only falls on bit 1 capture.
    wr(3'd4, 32'h0);
    wr(3'd5, 32'h2);
    wr(3'd2, 32'h2);
    wr(3'd6, 32'h0);
    wr(3'd3, 32'hF);
    in_port[1] = 1'b1;
    repeat (6) rd(3'd3);
    chk("rise_masked_cap", readdata, 32'h0);
    chk("rise_masked_irq", {31'b0, irq}, 32'h0);
    in_port[1] = 1'b0;
    repeat (6) rd(3'd3);
    chk("fall_cap", readdata, 32'h2);
    chk("fall_irq", {31'b0, irq}, 32'h1);

    // Clear in the same cycle as a new fall: the new edge wins.
    in_port[1] = 1'b1;
    repeat (6) rd(3'd3);
    in_port[1] = 1'b0;
    rd(3'd3);
    rd(3'd3);
    wr(3'd3, 32'h2);
    chk("clr_vs_edge_irq", {31'b0, irq}, 32'h1);
    rd(3'd3);
    chk("clr_vs_edge_cap", readdata, 32'h2);

    // Ordinary clear.
    wr(3'd3, 32'h2);
    chk("clear_irq", {31'b0, irq}, 32'h0);
    rd(3'd3);
    chk("clear_cap", readdata, 32'h0);

    // Full-width instance: all bits rise, half of them unmasked.
    wr(3'd4, 32'hFFFF_FFFF);
    wr(3'd2, 32'h0000_FFFF);
    in32 = 32'hFFFF_FFFF;
    repeat (5) rd(3'd3);
    chk("w32_capture", readdata32, 32'hFFFF_FFFF);
    rd(3'd7);
    chk("w32_status", readdata32, 32'h0000_FFFF);
    chk("w32_irq", {31'b0, irq32}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
